commit_arbiter: RTL
===================

Name: commit_arbiter

Overview:
- Sits directly downstream of the reservation-station execution units (MUL, ADD, DIV, ...).
- Collects their commit requests and grants exactly one station per cycle with round-robin fairness.
- Registers the winner's commit packet and drives it onto the shared commit bus that all stations and the register file snoop.
- Supplies the per-station iCommitGranted that each station waits on.

Parameters:
- NUM_STATIONS, 4, number of requesting stations (2..16).
- PACKET_W, `COMMIT_PACKET_SIZE, width of one station's commit packet (RSID, WE, DST, X/Y/Z).

Ports:
- Clock  in  1  system clock; everything is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- iCommitRequest  in  NUM_STATIONS  bit i high = station i holds a finished result.
- iCommitData  in  NUM_STATIONS*PACKET_W  packet of station i at bits [i*PACKET_W +: PACKET_W].
- iStall  in  1  commit bus consumer cannot accept a packet this cycle.
- oCommitGranted  out  NUM_STATIONS  one-hot, one-cycle grant pulse to the winner.
- oCommitValid  out  1  oCommitData holds a valid packet this cycle.
- oCommitData  out  PACKET_W  registered packet of the last winner.
- oWinnerId  out  log2(NUM_STATIONS)  index of the current winner, valid while oCommitValid is high.

Behaviour:
- Reset: oCommitGranted=0, oCommitValid=0, oCommitData=0, oWinnerId=0, round-robin pointer=0, mask register=0. Reset wins over every other event, including a grant in flight. No grant is issued in the cycle Reset is high.
- Eligible set: iCommitRequest & ~mask.
  - mask holds the previous cycle's oCommitGranted.
  - Reason: a station drops its request only one cycle after seeing the grant, so its stale request must not win twice.
- Arbitration each edge where Reset=0 and iStall=0:
  - If the eligible set is non-zero, pick the first set bit searching from pointer, pointer+1, ... and wrapping modulo NUM_STATIONS.
  - Register the result: oCommitGranted = one-hot(winner), oCommitData = packet of winner, oWinnerId = winner, oCommitValid = 1, pointer = (winner+1) mod NUM_STATIONS.
  - If the eligible set is empty: oCommitGranted=0, oCommitValid=0, pointer unchanged, oCommitData holds its value.
- Latency: a request present at edge N is granted at earliest at edge N+1. oCommitGranted and oCommitValid rise together in the same cycle.
- Throughput: one packet per cycle while at least two stations request. A single station requesting continuously gets one grant every 2 cycles, because of the mask.
- Stall: with iStall=1 at an edge, oCommitGranted is 0 and oCommitValid is 0; pointer and mask are unchanged; no packet is lost. Stations keep their requests asserted. Arbitration resumes on the first edge with iStall=0.
- Simultaneous request and grant deassertion by the same station: the mask covers it, and the winner is never re-granted in the next cycle.
- Requests deasserting without a grant are legal and are simply ignored.
- Wrap-around: the pointer runs from NUM_STATIONS-1 back to 0.
- A request from a station index >= NUM_STATIONS is not possible (width is fixed).
- Fairness bound: a continuously requesting station is granted within NUM_STATIONS arbitration cycles.

Decomposition:
- Shared definitions include file: COMMIT_PACKET_SIZE and its range macros (COMMIT_RSID_RNG, COMMIT_WE_RNG, COMMIT_DST_RNG, X/Y/Z_RNG). NUM_STATIONS default `NUM_RS_STATIONS is added there.
- One sub-module: rr_priority_picker.
  - Purely combinational.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any-flag.
  - Implemented as a double-width rotate-and-find-first.
- Pointer, mask and output registers live in commit_arbiter.

Test Plan:
- Reset mid-operation: stations 1 and 2 requesting, Reset asserted after first grant -> next cycle all outputs 0, pointer 0; after release station 1 is granted first.
- Single requester: station 2 holds its request with packet 0xA5 for 6 cycles -> grants at cycles 1, 3, 5; oCommitData=0xA5, oWinnerId=2 each time; oCommitValid low at cycles 2, 4, 6.
- All four request from cycle 0 and each drops its request one cycle after its grant -> grant order 0, 1, 2, 3 on consecutive cycles; oCommitValid high for 4 consecutive cycles, then low.
- Wrap-around: pointer=3, requests from 0 and 3 -> 3 wins, then 0 wins; pointer ends at 1.
- Stall: requests from 1 and 3, iStall high for 3 cycles -> no grants and oCommitValid=0 during the stall; first cycle after release grants 1, next cycle grants 3.
- Fairness soak: random requests, held until granted, over 10k cycles -> scoreboard checks each packet committed exactly once, no station waits more than NUM_STATIONS eligible cycles, and oCommitGranted is always one-hot-or-zero.

Source files
------------

// File: rtl/commit_arbiter_pkg.sv
// Shared commit-bus definitions: packet layout macros and the default arbiter sizing.
// Bit ranges within one commit packet; X/Y/Z carry the 16-bit result lanes.
`ifndef COMMIT_DEFS_SVH
`define COMMIT_DEFS_SVH
`define COMMIT_RSID_RNG 3:0
`define COMMIT_WE_RNG 4
`define COMMIT_DST_RNG 9:5
`define X_RNG 25:10
`define Y_RNG 41:26
`define Z_RNG 57:42
`define COMMIT_PACKET_SIZE 58
`define NUM_RS_STATIONS 4
`endif

package commit_arbiter_pkg;
  localparam int COMMIT_PACKET_SIZE = `COMMIT_PACKET_SIZE;
  localparam int NUM_RS_STATIONS = `NUM_RS_STATIONS;
endpackage

// File: rtl/commit_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_priority_picker #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  iRequest,
  input  logic [IW-1:0] iPointer,
  output logic [N-1:0]  oGrant,
  output logic [IW-1:0] oIndex,
  output logic          oAny
);
  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [IW:0]    sum;
  logic           found;

  always_comb begin
    doubled = {iRequest, iRequest};
    // Slicing the doubled vector at the pointer rotates the pointer's station to bit 0.
    rotated = doubled[{1'b0, iPointer} +: N];
    found   = 1'b0;
    sum     = '0;
    oIndex  = '0;
    oGrant  = '0;
    for (int k = 0; k < N; k++) begin
      if (rotated[k] && !found) begin
        found = 1'b1;
        sum = {1'b0, iPointer} + (IW+1)'(k);
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        oIndex = sum[IW-1:0];
      end
    end
    oAny = found;
    oGrant[oIndex] = found;
  end
endmodule

// File: rtl/commit_arbiter.sv
// Commit-bus arbiter: grants one reservation station per cycle round-robin and
// registers the winner's packet onto the shared commit bus.
module commit_arbiter
  import commit_arbiter_pkg::*;
#(
  parameter int NUM_STATIONS = NUM_RS_STATIONS,
  parameter int PACKET_W = COMMIT_PACKET_SIZE,
  localparam int IDX_W = (NUM_STATIONS > 1) ? $clog2(NUM_STATIONS) : 1
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [NUM_STATIONS-1:0]      iCommitRequest,
  input  logic [NUM_STATIONS*PACKET_W-1:0] iCommitData,
  input  logic                         iStall,
  output logic [NUM_STATIONS-1:0]      oCommitGranted,
  output logic                         oCommitValid,
  output logic [PACKET_W-1:0]          oCommitData,
  output logic [IDX_W-1:0]             oWinnerId
);
  logic [NUM_STATIONS-1:0] mask;
  logic [NUM_STATIONS-1:0] eligible;
  logic [NUM_STATIONS-1:0] pickGrant;
  logic [IDX_W-1:0]        rrPointer;
  logic [IDX_W-1:0]        pickIndex;
  logic [IDX_W-1:0]        nextPointer;
  logic                    pickAny;

  // A station still shows its request the cycle after its grant; the mask hides it.
  assign eligible = iCommitRequest & ~mask;

  rr_priority_picker #(.N(NUM_STATIONS)) uPicker (
    .iRequest (eligible),
    .iPointer (rrPointer),
    .oGrant   (pickGrant),
    .oIndex   (pickIndex),
    .oAny     (pickAny)
  );

  always_comb begin
    nextPointer = pickIndex + IDX_W'(1);
    if (pickIndex == IDX_W'(NUM_STATIONS - 1)) nextPointer = '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      oCommitGranted <= '0;
      oCommitValid   <= 1'b0;
      oCommitData    <= '0;
      oWinnerId      <= '0;
      rrPointer      <= '0;
      mask           <= '0;
    end else if (iStall) begin
      // Pointer and mask freeze so arbitration resumes exactly where it stopped.
      oCommitGranted <= '0;
      oCommitValid   <= 1'b0;
    end else begin
      oCommitGranted <= pickGrant;
      oCommitValid   <= pickAny;
      mask           <= pickGrant;
      if (pickAny) begin
        oCommitData <= iCommitData[int'(pickIndex)*PACKET_W +: PACKET_W];
        oWinnerId   <= pickIndex;
        rrPointer   <= nextPointer;
      end
    end
  end
endmodule
